// File: rtl/decode_stage.sv
// decode_stage -- instruction decode stage of the 16-bit pipelined core.
//
// Decodes one instruction word per cycle into a registered control/operand
// bundle for Execute, owns the 32x16 register file (async read, writeback
// write port), detects load-use hazards and honours branch flush.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   defined   : a same-cycle writeback to the index being read forwards wb_data
//   undefined : the read returns the stored (old) value
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   if_valid/if_instr/if_npc  instruction + next-PC from fetch
//   flush                 taken branch from Execute, squashes current decode
//   wb_en/wb_index/wb_data    register-file write port
//   stall_out             combinational: fetch must hold this cycle
//   control_out, dest_index_out, reg1_data, reg2_data, npc_out, immediate,
//   dest_wr_en            registered bundle to Execute
module decode_stage #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_npc,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_index,
  input  logic [15:0] wb_data,
  output logic        stall_out,
  output logic [4:0]  control_out,
  output logic [4:0]  dest_index_out,
  output logic [15:0] reg1_data,
  output logic [15:0] reg2_data,
  output logic [15:0] npc_out,
  output logic [6:0]  immediate,
  output logic        dest_wr_en
);

  localparam logic [3:0] OP_NOP   = 4'd0,  OP_SUB   = 4'd1,  OP_ADD    = 4'd2,
                         OP_ADDI  = 4'd3,  OP_SHLLI = 4'd4,  OP_SHRLI  = 4'd5,
                         OP_JUMP  = 4'd6,  OP_JUMPL = 4'd7,  OP_JUMPG  = 4'd8,
                         OP_JUMPE = 4'd9,  OP_JUMPNE= 4'd10, OP_CMP    = 4'd11,
                         OP_LOAD  = 4'd12, OP_LOADI = 4'd13, OP_STORE  = 4'd14,
                         OP_MOV   = 4'd15;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [4:0]  dest;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] npc;
    logic [6:0]  imm;
    logic        wr;
  } bundle_t;

  bundle_t     q, dec;
  logic [15:0] rf [NUM_REGS];
  logic [3:0]  op;
  logic [4:0]  ra, rb;
  logic [15:0] rd_a, rd_b;
  logic        use_ra, use_rb, hazard;

  assign op = if_instr[15:12];
  assign ra = if_instr[11:7];
  assign rb = if_instr[6:2];

  // Register-file read with optional same-cycle writeback forwarding.
  function automatic logic [15:0] rf_rd(input logic [4:0] idx);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_index == idx) return wb_data;
`endif
    return rf[idx];
  endfunction

  assign rd_a = rf_rd(ra);
  assign rd_b = rf_rd(rb);

  always_comb begin
    dec      = '0;
    use_ra   = 1'b0;
    use_rb   = 1'b0;
    dec.ctrl = {1'b0, op};
    dec.npc  = if_npc;
    dec.imm  = if_instr[6:0];
    unique case (op)
      OP_SUB, OP_ADD, OP_CMP, OP_LOAD, OP_STORE, OP_MOV: begin
        dec.r1 = rd_a; dec.r2 = rd_b; dec.dest = ra;
        use_ra = 1'b1; use_rb = 1'b1;
      end
      OP_ADDI, OP_SHLLI, OP_SHRLI: begin
        dec.r1 = rd_a; dec.dest = ra; use_ra = 1'b1;
      end
      OP_LOADI: dec.dest = ra;
      // Branches carry the tested register in the second operand slot.
      OP_JUMP, OP_JUMPL, OP_JUMPG, OP_JUMPE, OP_JUMPNE: begin
        dec.r2 = rd_a; use_ra = 1'b1;
      end
      OP_NOP: ;
      default: ;
    endcase
    dec.wr = op inside {OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
                        OP_LOAD, OP_LOADI, OP_MOV};
  end

  // The inserted bubble clears control_out, so the hazard self-clears after
  // one cycle and the held instruction decodes on the next edge.
  assign hazard = !flush && if_valid && (q.ctrl == {1'b0, OP_LOAD}) &&
                  ((use_ra && ra == q.dest) || (use_rb && rb == q.dest));
  assign stall_out = hazard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       q <= '0;
    else if (flush || hazard || !if_valid) q <= '0;
    else                                q <= dec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_index] <= wb_data;
    end
  end

  assign control_out    = q.ctrl;
  assign dest_index_out = q.dest;
  assign reg1_data      = q.r1;
  assign reg2_data      = q.r2;
  assign npc_out        = q.npc;
  assign immediate      = q.imm;
  assign dest_wr_en     = q.wr;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid, flush, wb_en;
  logic [15:0] if_instr, if_npc, wb_data;
  logic [4:0]  wb_index;
  logic        stall_out, dest_wr_en;
  logic [4:0]  control_out, dest_index_out;
  logic [15:0] reg1_data, reg2_data, npc_out;
  logic [6:0]  immediate;

  int total = 0;
  int bad   = 0;

  decode_stage #(.NUM_REGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_npc(if_npc), .flush(flush), .wb_en(wb_en), .wb_index(wb_index),
    .wb_data(wb_data), .stall_out(stall_out), .control_out(control_out),
    .dest_index_out(dest_index_out), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .npc_out(npc_out), .immediate(immediate),
    .dest_wr_en(dest_wr_en)
  );

  always #5 clk = ~clk;

  // Reference model: expected bundle and register contents.
  typedef struct {
    logic [4:0]  ctrl;
    logic [4:0]  dest;
    logic [15:0] r1, r2, npc;
    logic [6:0]  imm;
    logic        wr;
  } exp_t;

  logic [15:0] m_rf [32];
  exp_t        mb;
  logic        last_stall;

  function automatic exp_t zero_b();
    exp_t b;
    b.ctrl = '0; b.dest = '0; b.r1 = '0; b.r2 = '0; b.npc = '0; b.imm = '0; b.wr = 1'b0;
    return b;
  endfunction

  function automatic logic [15:0] rdm(input logic [4:0] i);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_index == i) return wb_data;
`endif
    return m_rf[i];
  endfunction

  function automatic exp_t m_decode();
    exp_t b = zero_b();
    int   op = int'(if_instr[15:12]);
    logic [4:0] ra = if_instr[11:7];
    logic [4:0] rb = if_instr[6:2];
    b.ctrl = 5'(op); b.npc = if_npc; b.imm = if_instr[6:0];
    if (op inside {1, 2, 11, 12, 14, 15}) begin b.r1 = rdm(ra); b.r2 = rdm(rb); b.dest = ra; end
    else if (op inside {3, 4, 5}) begin b.r1 = rdm(ra); b.dest = ra; end
    else if (op == 13) b.dest = ra;
    else if (op inside {[6:10]}) b.r2 = rdm(ra);
    b.wr = op inside {1, 2, 3, 4, 5, 12, 13, 15};
    return b;
  endfunction

  function automatic logic m_stall();
    int op = int'(if_instr[15:12]);
    logic ua = op != 0 && op != 13;
    logic ub = op inside {1, 2, 11, 12, 14, 15};
    if (!reset_n || flush || !if_valid || mb.ctrl != 5'd12) return 1'b0;
    return (ua && if_instr[11:7] == mb.dest) || (ub && if_instr[6:2] == mb.dest);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out();
    chk("control",  16'(control_out),    16'(mb.ctrl));
    chk("dest",     16'(dest_index_out), 16'(mb.dest));
    chk("reg1",     reg1_data,           mb.r1);
    chk("reg2",     reg2_data,           mb.r2);
    chk("npc",      npc_out,             mb.npc);
    chk("imm",      16'(immediate),      16'(mb.imm));
    chk("wr_en",    16'(dest_wr_en),     16'(mb.wr));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    mb = zero_b();
    last_stall = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] npc,
                       input logic fl, input logic we, input logic [4:0] wi,
                       input logic [15:0] wd);
    if_valid = v; if_instr = ins; if_npc = npc; flush = fl;
    wb_en = we; wb_index = wi; wb_data = wd;
  endtask

  // One clock: check stall before the edge, advance model, check bundle after.
  task automatic cyc();
    exp_t nb;
    logic st;
    #1;
    st = m_stall();
    chk("stall", 16'(stall_out), 16'(st));
    nb = (flush || st || !if_valid) ? zero_b() : m_decode();
    @(posedge clk);
    if (wb_en) m_rf[wb_index] = wb_data;
    mb = nb;
    last_stall = st;
    #1;
    chk_out();
  endtask

  initial begin
    logic [15:0] ins, exp_mov;
    logic [3:0]  rop;
    drive(0, 16'h0, 16'h0, 0, 0, 5'd0, 16'h0);
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("rst_stall", 16'(stall_out), 16'h0);
    chk_out();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Writebacks then SUB ra=1 rb=2
    drive(0, 16'h0, 16'h0, 0, 1, 5'd1, 16'd10); cyc();
    drive(0, 16'h0, 16'h0, 0, 1, 5'd2, 16'd3);  cyc();
    drive(1, 16'h1088, 16'h0011, 0, 0, 5'd0, 16'h0); cyc();
    chk("sub_ctrl", 16'(control_out), 16'd1);
    chk("sub_dest", 16'(dest_index_out), 16'd1);
    chk("sub_r1", reg1_data, 16'd10);
    chk("sub_r2", reg2_data, 16'd3);
    chk("sub_wr", 16'(dest_wr_en), 16'd1);

    // ADDI ra=2 imm=7 with R2=10, then LOADI ra=3 imm=31
    drive(0, 16'h0, 16'h0, 0, 1, 5'd2, 16'd10); cyc();
    drive(1, 16'h3107, 16'h0012, 0, 0, 5'd0, 16'h0); cyc();
    chk("addi_r1", reg1_data, 16'd10);
    chk("addi_r2", reg2_data, 16'd0);
    chk("addi_imm", 16'(immediate), 16'd7);
    chk("addi_wr", 16'(dest_wr_en), 16'd1);
    drive(1, 16'hD19F, 16'h0013, 0, 0, 5'd0, 16'h0); cyc();
    chk("loadi_r1", reg1_data, 16'd0);
    chk("loadi_imm", 16'(immediate), 16'd31);

    // LOAD ra=4 rb=1, then dependent ADD ra=5 rb=4
    drive(0, 16'h0, 16'h0, 0, 1, 5'd4, 16'h0055); cyc();
    drive(1, 16'hC204, 16'h0014, 0, 0, 5'd0, 16'h0); cyc();
    drive(1, 16'h2290, 16'h0015, 0, 0, 5'd0, 16'h0);
    #1; chk("hz_stall", 16'(stall_out), 16'd1);
    cyc();
    chk("hz_bubble", 16'(control_out), 16'd0);
    cyc();
    chk("hz_stall_clr", 16'(last_stall), 16'd0);
    chk("hz_add_ctrl", 16'(control_out), 16'd2);
    chk("hz_add_r2", reg2_data, 16'h0055);

    // JUMPL ra=6 imm=1, then same with flush
    drive(0, 16'h0, 16'h0, 0, 1, 5'd6, 16'd8); cyc();
    drive(1, 16'h7301, 16'd5, 0, 0, 5'd0, 16'h0); cyc();
    chk("jl_r1", reg1_data, 16'd0);
    chk("jl_r2", reg2_data, 16'd8);
    chk("jl_npc", npc_out, 16'd5);
    chk("jl_wr", 16'(dest_wr_en), 16'd0);
    drive(1, 16'h7301, 16'd5, 1, 0, 5'd0, 16'h0); cyc();
    chk("fl_ctrl", 16'(control_out), 16'd0);
    chk("fl_npc", npc_out, 16'd0);
    chk("fl_r2", reg2_data, 16'd0);

    // MOV ra=0 rb=7 while writing R7
    drive(1, 16'hF01C, 16'h0020, 0, 1, 5'd7, 16'h1234); cyc();
`ifdef DECODE_WB_BYPASS_EN
    exp_mov = 16'h1234;
`else
    exp_mov = 16'h0000;
`endif
    chk("mov_r2", reg2_data, exp_mov);

    // Flush overrides a pending hazard
    drive(1, 16'hC204, 16'h0021, 0, 0, 5'd0, 16'h0); cyc();
    drive(1, 16'h2290, 16'h0022, 1, 0, 5'd0, 16'h0); cyc();
    chk("fl_hz_stall", 16'(last_stall), 16'd0);

    // Randomized traffic; fetch holds while the model says stall
    ins = 16'h0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        rop = 4'($urandom_range(0, 15));
        ins = {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom)};
        if_valid = ($urandom_range(0, 9) < 8);
        if_npc   = 16'($urandom);
      end
      if_instr = ins;
      flush    = ($urandom_range(0, 9) == 0);
      wb_en    = ($urandom_range(0, 9) < 4);
      wb_index = 5'($urandom_range(0, 7));
      wb_data  = 16'($urandom);
      cyc();
    end

    // Reset asserted mid-stall
    drive(1, 16'hC204, 16'h0030, 0, 0, 5'd0, 16'h0); cyc();
    drive(1, 16'h2290, 16'h0031, 0, 0, 5'd0, 16'h0);
    #1; chk("rs_stall_pre", 16'(stall_out), 16'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rs_stall", 16'(stall_out), 16'd0);
    chk_out();
    @(negedge clk); reset_n = 1'b1;
    drive(1, 16'h2290, 16'h0032, 0, 0, 5'd0, 16'h0); cyc();
    chk("rs_add_ctrl", 16'(control_out), 16'd2);
    chk("rs_rf_clear", reg2_data, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
